// File: rtl/vga_scan_ctrl.sv
// vga_scan_ctrl -- raster scan controller for the 640x480@60 VGA output path.
//
// Produces the pixel coordinate (o_VGA_X/o_VGA_Y) that the visualizer renders.
// It then captures the visualizer's colour for that coordinate and presents it
// on the DAC pins together with sync and blank signals delayed to match.
//
// Ports:
//   i_clk, i_rst_n           clock, asynchronous active-low reset
//   i_pix_en                 pixel tick; all state advances only when 1
//   o_VGA_X, o_VGA_Y         live h/v counters (not pipelined)
//   i_VGA_R/G/B              renderer colour for o_VGA_X/Y, RGB_LAT ticks late
//   VGA_R/G/B                registered DAC colour, zero outside visible area
//   VGA_HS, VGA_VS           registered active-low syncs
//   VGA_BLANK_N              registered, 1 in the visible region
//   VGA_SYNC_N               tied 0
//   o_frame_start            1 while the outputs present (0,0) on a pixel tick
//
// Build option: define VGA_SCAN_TESTBARS_EN to ignore i_VGA_R/G/B and output
// eight 80-pixel-wide vertical colour bars instead.

module vga_scan_ctrl #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter int unsigned RGB_LAT  = 0
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_pix_en,
  output logic [10:0] o_VGA_X,
  output logic [10:0] o_VGA_Y,
  input  logic [7:0]  i_VGA_R,
  input  logic [7:0]  i_VGA_G,
  input  logic [7:0]  i_VGA_B,
  output logic [7:0]  VGA_R,
  output logic [7:0]  VGA_G,
  output logic [7:0]  VGA_B,
  output logic        VGA_HS,
  output logic        VGA_VS,
  output logic        VGA_BLANK_N,
  output logic        VGA_SYNC_N,
  output logic        o_frame_start
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_LAST   = 11'(V_TOTAL - 1);
  localparam logic [10:0] H_ACT    = 11'(H_ACTIVE);
  localparam logic [10:0] V_ACT    = 11'(V_ACTIVE);
  localparam logic [10:0] HS_FIRST = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_LAST  = 11'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [10:0] VS_FIRST = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VS_LAST  = 11'(V_ACTIVE + V_FP + V_SYNC - 1);

  // Per-position status carried down the delay line.
  typedef struct packed {
    logic       active;
    logic       hs_n;
    logic       vs_n;
    logic       origin;   // position is (0,0): drives o_frame_start
`ifdef VGA_SCAN_TESTBARS_EN
    logic [2:0] bar;      // x/80, only meaningful while active
`endif
  } stat_t;

  logic [10:0] h_cnt_q, h_cnt_d;
  logic [10:0] v_cnt_q, v_cnt_d;
  stat_t       raw_st;
  stat_t       tap_st;
  stat_t       dl_q [RGB_LAT+1];
  logic [23:0] col_in;
  logic [23:0] rgb_d, rgb_q;

  // ---------------------------------------------------------------- counters
  always_comb begin
    h_cnt_d = h_cnt_q + 11'd1;
    v_cnt_d = v_cnt_q;
    if (h_cnt_q == H_LAST) begin
      h_cnt_d = '0;
      v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 11'd1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
    end else if (i_pix_en) begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
    end
  end

  assign o_VGA_X = h_cnt_q;
  assign o_VGA_Y = v_cnt_q;

  // ------------------------------------------------------------ raw status
  always_comb begin
    raw_st        = '0;
    raw_st.active = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
    raw_st.hs_n   = !((h_cnt_q >= HS_FIRST) && (h_cnt_q <= HS_LAST));
    raw_st.vs_n   = !((v_cnt_q >= VS_FIRST) && (v_cnt_q <= VS_LAST));
    raw_st.origin = (h_cnt_q == '0) && (v_cnt_q == '0);
`ifdef VGA_SCAN_TESTBARS_EN
    raw_st.bar    = 3'(h_cnt_q / 11'd80);
`endif
  end

  // -------------------------------------------------------------- delay line
  // dl_q[RGB_LAT] is the output stage; it updates on the same edge as the
  // colour register, so both take their input from the stage just before it
  // (or straight from the counters when the renderer has no extra latency).
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int unsigned i = 0; i <= RGB_LAT; i++) begin
        dl_q[i]      <= '0;
        dl_q[i].hs_n <= 1'b1;
        dl_q[i].vs_n <= 1'b1;
      end
    end else if (i_pix_en) begin
      dl_q[0] <= raw_st;
      for (int unsigned i = 1; i <= RGB_LAT; i++) begin
        dl_q[i] <= dl_q[i-1];
      end
    end
  end

  if (RGB_LAT == 0) begin : g_tap_raw
    assign tap_st = raw_st;
  end else begin : g_tap_dly
    assign tap_st = dl_q[RGB_LAT-1];
  end

  // ------------------------------------------------------------ colour path
`ifdef VGA_SCAN_TESTBARS_EN
  // Bar order white, yellow, cyan, green, magenta, red, blue, black: each
  // channel is the inverse of one bit of the bar index.
  assign col_in = {{8{~tap_st.bar[1]}}, {8{~tap_st.bar[2]}}, {8{~tap_st.bar[0]}}};

  logic unused_rgb;
  assign unused_rgb = ^{i_VGA_R, i_VGA_G, i_VGA_B};
`else
  assign col_in = {i_VGA_R, i_VGA_G, i_VGA_B};
`endif

  always_comb begin
    rgb_d = '0;
    if (tap_st.active) rgb_d = col_in;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rgb_q <= '0;
    end else if (i_pix_en) begin
      rgb_q <= rgb_d;
    end
  end

  // ----------------------------------------------------------------- outputs
  assign VGA_R         = rgb_q[23:16];
  assign VGA_G         = rgb_q[15:8];
  assign VGA_B         = rgb_q[7:0];
  assign VGA_HS        = dl_q[RGB_LAT].hs_n;
  assign VGA_VS        = dl_q[RGB_LAT].vs_n;
  assign VGA_BLANK_N   = dl_q[RGB_LAT].active;
  assign VGA_SYNC_N    = 1'b0;
  // Gated by i_pix_en so the pulse lasts one i_clk cycle even when the
  // outputs hold (0,0) across several enable-low cycles.
  assign o_frame_start = i_pix_en & dl_q[RGB_LAT].origin;

endmodule
